// File: rtl/nfa_stream_ctrl.sv
// Packet sequencer for a bank of NFA engines: clears the engines, streams bytes,
// captures the first-match offset and hands one result per packet downstream.
//
// state  | meaning
// IDLE   | waiting for the first byte of a packet
// CLEAR  | eng_sod pulse; counter, hit and offset cleared
// STREAM | bytes accepted and broadcast to the engines
// DRAIN  | last byte's match settles; result captured
// REPORT | result offered until r_ready
module nfa_stream_ctrl #(
    parameter int N_ENG = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic [7:0]       eng_char,
    output logic             eng_en,
    output logic             eng_sod,
    input  logic [N_ENG-1:0] eng_match,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [N_ENG-1:0] r_match,
    output logic             r_hit,
    output logic [CNT_W-1:0] r_offset,
    output logic [CNT_W-1:0] r_len
);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, REPORT} state_t;

    state_t           state, state_nxt;
    logic             accept;
    logic             any_match;
    logic             hit;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last_idx;
    logic [CNT_W-1:0] offset;

    assign any_match = |eng_match;
    assign s_ready   = (state == STREAM);
    assign accept    = s_ready & s_valid;
    assign eng_en    = accept;
    assign eng_char  = s_data;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s_valid) state_nxt = CLEAR;
            CLEAR:   state_nxt = STREAM;
            STREAM:  if (accept && s_last) state_nxt = DRAIN;
            DRAIN:   state_nxt = REPORT;
            REPORT:  if (r_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            eng_sod <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            eng_sod <= (state_nxt == CLEAR);
            r_valid <= (state_nxt == REPORT);
        end
    end

    // eng_match lags the accepted byte by one cycle, so last_idx still names
    // the byte that caused it when the hit is first seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            last_idx <= '0;
            hit      <= 1'b0;
            offset   <= '0;
            r_match  <= '0;
            r_hit    <= 1'b0;
            r_offset <= '0;
            r_len    <= '0;
        end else if (state == CLEAR) begin
            cnt      <= '0;
            last_idx <= '0;
            hit      <= 1'b0;
            offset   <= '0;
        end else begin
            if (accept) begin
                last_idx <= cnt;
                if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
            end
            if ((state == STREAM || state == DRAIN) && any_match && !hit) begin
                hit    <= 1'b1;
                offset <= last_idx;
            end
            if (state == DRAIN) begin
                r_match  <= eng_match;
                r_hit    <= hit | any_match;
                r_len    <= cnt;
                // a match first seen here belongs to the last byte
                r_offset <= hit ? offset : (any_match ? last_idx : '0);
            end
        end
    end

endmodule

// File: doc/nfa_stream_ctrl.md
NFA_STREAM_CTRL -- requirements
Module: nfa_stream_ctrl

Interface
REQ-001 Parameter N_ENG, default 8: number of NFA engines driven in parallel; width of the match vector.
REQ-002 Parameter CNT_W, default 16: width of the byte counter, the offset field and the length field.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port s_valid, input, 1: an input byte is offered.
REQ-006 Port s_ready, output, 1: the controller accepts the byte this cycle.
REQ-007 Port s_data, input, 8: input byte.
REQ-008 Port s_last, input, 1: the offered byte is the last byte of the packet.
REQ-009 Port eng_char, output, 8: byte broadcast to all engines.
REQ-010 Port eng_en, output, 1: engine clock enable.
REQ-011 Port eng_sod, output, 1: engine start-of-data clear.
REQ-012 Port eng_match, input, N_ENG: sticky registered match outputs of the engines.
REQ-013 Port r_valid, output, 1: a per-packet result is available.
REQ-014 Port r_ready, input, 1: the result consumer accepts the result.
REQ-015 Port r_match, output, N_ENG: snapshot of eng_match at the end of the packet.
REQ-016 Port r_hit, output, 1: at least one engine matched in the packet.
REQ-017 Port r_offset, output, CNT_W: 0-based index of the byte that caused the first match.
REQ-018 Port r_len, output, CNT_W: number of bytes accepted in the packet.

Function
REQ-019 The controller SHALL implement an FSM with states IDLE, CLEAR, STREAM, DRAIN and REPORT.
REQ-020 IDLE: s_ready=0, eng_en=0; on s_valid=1 the FSM SHALL go to CLEAR.
REQ-021 CLEAR: eng_sod=1 for exactly one cycle, s_ready=0, eng_en=0; the byte counter, hit flag and offset SHALL be cleared; next state is STREAM.
REQ-022 STREAM: s_ready=1; eng_char=s_data combinationally; eng_en=s_valid&s_ready; the engines consume the byte on the same edge on which it is accepted.
REQ-023 STREAM with s_valid=0: eng_en=0 and the engines hold their state; no timeout applies.
REQ-024 On each accepted byte, the byte counter SHALL increment by 1 and saturate at 2^CNT_W-1.
REQ-025 On each accepted byte, last_idx SHALL be registered as the pre-increment count of that byte.
REQ-026 Match latency: the effect of the byte accepted at edge t SHALL be visible on eng_match in cycle t+1.
REQ-027 In STREAM or DRAIN, if eng_match!=0 and the hit flag is 0, then on that edge hit SHALL be set to 1 and offset SHALL be set to last_idx.
REQ-028 Once hit is set, offset SHALL NOT change until the next CLEAR.
REQ-029 An accept with s_last=1 SHALL move the FSM to DRAIN; this also applies to a single-byte packet.
REQ-030 DRAIN lasts one cycle with s_ready=0 and eng_en=0; at its edge, r_match is loaded from eng_match, r_hit from (hit or eng_match!=0), and r_len from the counter; next state is REPORT.
REQ-031 REPORT: r_valid=1, and r_match, r_hit, r_offset and r_len are held stable.
REQ-032 REPORT with r_ready=1 SHALL complete the transfer; r_valid SHALL fall on the next edge and the FSM SHALL return to IDLE.
REQ-033 REPORT: s_ready=0, so a following packet is back-pressured until the result is consumed.
REQ-034 When r_hit=0, r_offset SHALL read 0.
REQ-035 s_last is ignored when s_valid=0.
REQ-036 eng_sod, r_valid and the FSM state are registered; s_ready and eng_en are decoded from the state and the inputs.

Reset
REQ-037 While rst=1: FSM=IDLE; s_ready, eng_en, r_valid, r_hit, r_match, r_offset, r_len, the counter and last_idx = 0; eng_sod=1.
REQ-038 On the first edge after rst falls, eng_sod SHALL return to 0.
REQ-039 rst asserted mid-packet or in REPORT SHALL drop the packet and any pending result with no output.

Verification
(Engine model: /a\n[abc:]*b/i; out is sticky until sod.)
REQ-040 Stream "A\nab" with s_last on "b", r_ready=1 -> one CLEAR cycle with eng_sod=1; r_valid=1 with r_hit=1, r_offset=3, r_len=4; IDLE after handoff.
REQ-041 Stream "xyz" -> r_hit=0, r_match=0, r_offset=0, r_len=3.
REQ-042 Stream "a\nb" + "b" -> r_offset=2 (first match), r_len=4; a second packet "zz" -> r_hit=0, proving eng_sod cleared the sticky match.
REQ-043 s_valid gaps of 3 cycles inside "a\n::b" -> same result as without gaps: r_offset=4, r_len=5.
REQ-044 Hold r_ready=0 for 10 cycles with the next packet pending -> r_* fields stable, s_ready=0 throughout; accept on r_ready=1.
REQ-045 Assert rst during the STREAM byte 2 -> all outputs 0, eng_sod=1; after release, a fresh packet reports correct r_len starting from 0.
